// File: rtl/seg7_reader.sv
// Recovers a two-digit decimal value from a multiplexed, active-low 7-segment bus.
// Each digit must hold steady for STABLE_CYCLES samples; units are captured first, then tens.
module seg7_reader #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] SEG,
    input  logic [1:0] AN,
    output logic [3:0] BCD_U,
    output logic [3:0] BCD_D,
    output logic [6:0] VALUE,
    output logic       VALID,
    output logic       ERR
);

    localparam int unsigned CW = 8;
    localparam int unsigned SW = 9;
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_PRE = CW'(STABLE_CYCLES - 2);
    localparam logic [6:0]    BLANK   = 7'b1111111;
    localparam logic [1:0]    AN_U    = 2'b10;
    localparam logic [1:0]    AN_D    = 2'b01;

    typedef enum logic [1:0] {CAP_U, CAP_D, PUBLISH} state_e;

    // Returns {decodable, digit}; a blank is only a legal digit in the tens position.
    function automatic logic [4:0] decode(input logic [6:0] pat, input logic is_tens);
        logic [4:0] r;
        case (pat)
            7'b1000000: r = {1'b1, 4'd0};
            7'b1111001: r = {1'b1, 4'd1};
            7'b0100100: r = {1'b1, 4'd2};
            7'b0110000: r = {1'b1, 4'd3};
            7'b0011001: r = {1'b1, 4'd4};
            7'b0010010: r = {1'b1, 4'd5};
            7'b0000010: r = {1'b1, 4'd6};
            7'b1111000: r = {1'b1, 4'd7};
            7'b0000000: r = {1'b1, 4'd8};
            7'b0011000: r = {1'b1, 4'd9};
            7'b0010000: r = {1'b1, 4'd9};
            7'b1111111: r = is_tens ? {1'b1, 4'd0} : {1'b0, 4'hF};
            default:    r = {1'b0, 4'hF};
        endcase
        return r;
    endfunction

    state_e         state_q, state_d;
    logic [SW-1:0]  sample_q, sample_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [6:0]     pat_u_q, pat_u_d, pat_d_q, pat_d_d;
    logic [3:0]     bcd_u_q, bcd_u_d, bcd_d_q, bcd_d_d;
    logic [6:0]     value_q, value_d;
    logic           valid_q, valid_d, err_q, err_d;

    logic           an_legal_c, match_c, accept_c;
    logic           store_u_c, store_d_c, publish_c, enter_c;
    logic [4:0]     dec_u_c, dec_d_c;

    assign an_legal_c = (AN == AN_U) || (AN == AN_D);
    assign match_c    = an_legal_c && ({AN, SEG} == sample_q);
    assign accept_c   = match_c && (cnt_q == CNT_PRE);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= CAP_U;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            CAP_U:   if (accept_c && AN == AN_U) state_d = CAP_D;
            CAP_D:   if (accept_c && AN == AN_D) state_d = PUBLISH;
            PUBLISH: state_d = CAP_U;
            default: state_d = CAP_U;
        endcase
    end

    // FSM outputs
    always_comb begin
        store_u_c = 1'b0;
        store_d_c = 1'b0;
        publish_c = 1'b0;
        case (state_q)
            CAP_U:   store_u_c = accept_c && (AN == AN_U);
            CAP_D:   store_d_c = accept_c && (AN == AN_D);
            PUBLISH: publish_c = 1'b1;
            default: ;
        endcase
    end

    assign enter_c = (state_d != state_q) && (state_d != PUBLISH);
    assign dec_u_c = decode(pat_u_q, 1'b0);
    assign dec_d_c = decode(pat_d_q, 1'b1);

    // Datapath next values
    always_comb begin
        sample_d = {AN, SEG};
        pat_u_d  = pat_u_q;
        pat_d_d  = pat_d_q;
        bcd_u_d  = bcd_u_q;
        bcd_d_d  = bcd_d_q;
        value_d  = value_q;
        err_d    = err_q;
        valid_d  = 1'b0;

        if (enter_c || !match_c)  cnt_d = '0;
        else if (cnt_q == CNT_MAX) cnt_d = CNT_MAX;
        else                       cnt_d = cnt_q + CW'(1);

        if (store_u_c) pat_u_d = SEG;
        if (store_d_c) pat_d_d = SEG;

        if (publish_c) begin
            valid_d = 1'b1;
            bcd_u_d = dec_u_c[3:0];
            bcd_d_d = dec_d_c[3:0];
            err_d   = !(dec_u_c[4] && dec_d_c[4]);
            value_d = err_d ? 7'd127
                            : 7'(7'(dec_d_c[3:0]) * 7'd10 + 7'(dec_u_c[3:0]));
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_q <= {2'b11, BLANK};
            cnt_q    <= '0;
            pat_u_q  <= BLANK;
            pat_d_q  <= BLANK;
            bcd_u_q  <= '0;
            bcd_d_q  <= '0;
            value_q  <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            sample_q <= sample_d;
            cnt_q    <= cnt_d;
            pat_u_q  <= pat_u_d;
            pat_d_q  <= pat_d_d;
            bcd_u_q  <= bcd_u_d;
            bcd_d_q  <= bcd_d_d;
            value_q  <= value_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    assign BCD_U = bcd_u_q;
    assign BCD_D = bcd_d_q;
    assign VALUE = value_q;
    assign VALID = valid_q;
    assign ERR   = err_q;

endmodule

// File: tb/tb_seg7_reader.sv
// Self-checking bench for seg7_reader: table of digit pairs plus hand-built
// glitch, reset and idle sequences, with a queue of expected publications.
module tb_seg7_reader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] SEG = 7'b1111111;
    logic [1:0] AN  = 2'b11;
    logic [3:0] BCD_U, BCD_D;
    logic [6:0] VALUE;
    logic       VALID, ERR;

    seg7_reader #(.STABLE_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .SEG(SEG), .AN(AN),
        .BCD_U(BCD_U), .BCD_D(BCD_D), .VALUE(VALUE), .VALID(VALID), .ERR(ERR)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] bu;
        logic [3:0] bd;
        logic [6:0] val;
        logic       err;
    } exp_t;

    typedef struct {
        logic [6:0] seg_u;
        logic [6:0] seg_d;
        exp_t       exp;
    } vec_t;

    vec_t  vecs [9];
    exp_t  sb_q [$];
    int    compared   = 0;
    int    mismatched = 0;
    int    valid_cnt  = 0;
    int    exp_pulses = 0;

    // Counts every VALID cycle seen, so stray pulses show up in the totals
    always @(posedge clk) begin
        #1;
        if (VALID === 1'b1) valid_cnt++;
    end

    task automatic drive(input logic [1:0] an, input logic [6:0] seg, input int n);
        AN  = an;
        SEG = seg;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_outs(input string name, input exp_t e);
        compared++;
        if ({BCD_U, BCD_D, VALUE, ERR} !== {e.bu, e.bd, e.val, e.err}) begin
            mismatched++;
            $display("FAIL %s: got U=%h D=%h V=%0d E=%b, want U=%h D=%h V=%0d E=%b",
                     name, BCD_U, BCD_D, VALUE, ERR, e.bu, e.bd, e.val, e.err);
        end
    endtask

    task automatic check_cnt(input string name, input int got, input int want);
        compared++;
        if (got != want) begin
            mismatched++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    // Idle the bus and wait (bounded) for one VALID pulse, then score it
    task automatic wait_valid(input string name);
        bit   found = 0;
        exp_t e;
        AN  = 2'b11;
        SEG = 7'b1111111;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (VALID === 1'b1) begin
                found = 1;
                break;
            end
        end
        e = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
        if (!found) begin
            compared++;
            mismatched++;
            $display("FAIL %s: VALID timeout, got none, want pulse", name);
        end else begin
            check_outs(name, e);
            @(negedge clk);
            check_cnt({name, "_pulse_width"}, int'(VALID), 0);
            repeat (3) @(negedge clk);
            check_outs({name, "_hold"}, e);
        end
    endtask

    task automatic run_pair(input string name, input logic [6:0] su,
                            input logic [6:0] sd, input exp_t e);
        drive(2'b10, su, 4);
        sb_q.push_back(e);
        exp_pulses++;
        drive(2'b01, sd, 4);
        wait_valid(name);
    endtask

    initial begin
        vecs[0] = '{7'b0010010, 7'b0100100, '{4'd5, 4'd2, 7'd25,  1'b0}};
        vecs[1] = '{7'b0000000, 7'b1111111, '{4'd8, 4'd0, 7'd8,   1'b0}};
        vecs[2] = '{7'b1111111, 7'b1111001, '{4'hF, 4'd1, 7'd127, 1'b1}};
        vecs[3] = '{7'b0011000, 7'b0011000, '{4'd9, 4'd9, 7'd99,  1'b0}};
        vecs[4] = '{7'b0010000, 7'b1111000, '{4'd9, 4'd7, 7'd79,  1'b0}};
        vecs[5] = '{7'b1000000, 7'b1111111, '{4'd0, 4'd0, 7'd0,   1'b0}};
        vecs[6] = '{7'b0100100, 7'b1010101, '{4'd2, 4'hF, 7'd127, 1'b1}};
        vecs[7] = '{7'b0000010, 7'b0110000, '{4'd6, 4'd3, 7'd36,  1'b0}};
        vecs[8] = '{7'b0011001, 7'b0011001, '{4'd4, 4'd4, 7'd44,  1'b0}};

        repeat (3) @(negedge clk);
        check_outs("reset_state", '0);
        check_cnt("reset_valid", int'(VALID), 0);
        rst = 1'b0;

        // No legal digit selection: nothing may ever publish
        drive(2'b11, 7'b0010010, 20);
        drive(2'b00, 7'b0010010, 20);
        check_outs("idle_outputs", '0);
        check_cnt("idle_no_valid", valid_cnt, 0);

        for (int i = 0; i < 9; i++)
            run_pair($sformatf("vec%0d", i), vecs[i].seg_u, vecs[i].seg_d, vecs[i].exp);

        // A 3-sample units glitch must be rejected in favour of the stable digit
        drive(2'b10, 7'b1000000, 3);
        drive(2'b10, 7'b1111001, 4);
        sb_q.push_back('{4'd1, 4'd1, 7'd11, 1'b0});
        exp_pulses++;
        drive(2'b01, 7'b1111001, 4);
        wait_valid("short_glitch");

        // Units captured, tens only partly stable, then reset discards the pair
        drive(2'b10, 7'b0000000, 4);
        drive(2'b01, 7'b0011001, 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_outs("mid_reset_outputs", '0);
        drive(2'b01, 7'b0011001, 8);
        drive(2'b11, 7'b1111111, 10);
        check_cnt("mid_reset_no_valid", valid_cnt, exp_pulses);
        check_outs("mid_reset_hold", '0);
        run_pair("after_reset", 7'b0010010, 7'b0100100, '{4'd5, 4'd2, 7'd25, 1'b0});

        // Units already stable on the tens digit must still be ignored while in CAP_D
        drive(2'b10, 7'b1111000, 4);
        drive(2'b10, 7'b0000000, 6);
        sb_q.push_back('{4'd7, 4'd6, 7'd67, 1'b0});
        exp_pulses++;
        drive(2'b01, 7'b0000010, 4);
        wait_valid("units_ignored_in_tens");

        repeat (5) @(negedge clk);
        check_cnt("total_valid_pulses", valid_cnt, exp_pulses);
        check_cnt("scoreboard_empty", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
